router_fifo: RTL and testbench
==============================

// Module: router_fifo
// PURPOSE
//  Per-port output FIFO of the 1x3 router, directly downstream of the register stage.
//  - Buffers the register stage's dout bytes for one destination port.
//  - Tags each entry with the lfd_state bit so the header byte is known on read.
//  - On read-out, tracks the remaining packet length from the header.
//  - Flags a packet in progress so the FSM and read side can sequence ports.
// PARAMETERS
//  DEPTH  16  entries; power of two, >=4
//  WIDTH  8   data byte width; entry = WIDTH+1 bits {lfd_tag, data}
// PORTS
//  clock       in   1      sole clock, all logic on posedge
//  reset       in   1      synchronous, active-high; full clear
//  soft_reset  in   1      sync active-high; port timeout flush (from sync block)
//  write_enb   in   1      write request from sync block, this port selected
//  read_enb    in   1      read request from destination
//  lfd_state   in   1      byte on data_in is a header; stored as tag bit
//  data_in     in   WIDTH  byte from register stage dout
//  full        out  1      DEPTH entries held
//  empty       out  1      zero entries held
//  pkt_busy    out  1      packet read-out in progress (len_cnt!=0)
//  data_out    out  WIDTH  registered read data
// BEHAVIOUR
//  - Pointers: wr_ptr and rd_ptr are log2(DEPTH)+1 bits; the extra MSB is the wrap bit.
//    - empty = (wr_ptr==rd_ptr)
//    - full  = (MSBs differ, low bits equal)
//    - full/empty are combinational from the pointers.
//  - Write accepted iff write_enb && !full:
//    - mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr++.
//    - write_enb while full is ignored: no pointer move, no data corruption.
//  - Read accepted iff read_enb && !empty:
//    - data_out <= mem[rd_ptr][WIDTH-1:0] on that edge (1-cycle latency); rd_ptr++.
//    - read_enb while empty is ignored; data_out holds its value.
//  - Simultaneous read+write: each is judged independently against pre-edge full/empty.
//    - At full, only the read occurs. At empty, only the write occurs.
//    - Otherwise both occur and the count is unchanged.
//  - len_cnt (7 bits): remaining bytes of the packet being read out.
//    - Read of a tagged entry loads len_cnt <= data[7:2] + 1 (payload + parity), then the header byte leaves.
//    - Read of an untagged entry with len_cnt!=0 decrements len_cnt.
//    - Tagged read while len_cnt!=0 (truncated packet) reloads; it does not decrement.
//    - Untagged read with len_cnt==0 leaves len_cnt at 0.
//    - pkt_busy = (len_cnt!=0).
//  - Wrap-around: pointers roll over modulo 2*DEPTH; no special case at the index boundary.
//  - reset (priority over all):
//    - wr_ptr, rd_ptr, len_cnt, data_out <= 0; so full=0, empty=1, pkt_busy=0.
//    - mem contents are don't-care.
//  - soft_reset (below reset, above read/write): same clears as reset, including data_out <= 0.
//    - Any read/write in that cycle is discarded.
//    - Asserted mid-packet, it drops the remainder of the packet.
//  - No combinational path from read_enb/write_enb to data_out.
// STRUCTURE
//  - Shared package router_pkg:
//    - WIDTH
//    - LEN_MSB=7 / LEN_LSB=2 header length field
//    - LEN_CNT_W=7
//    - FIFO_DEPTH default.
//  - One sub-module, router_fifo_mem: DEPTH x (WIDTH+1) simple dual-port RAM, sync write, sync read.
//  - Pointer logic, len_cnt and flags stay in router_fifo.
// TESTING
//  1. reset, then write header 8'h0D (len 3, tag=1), 3 payload bytes and a parity byte.
//     Read 5 times: data_out = 0D,p0,p1,p2,par, each one cycle after its read.
//     pkt_busy rises after the header read with len_cnt=4, falls after the parity read.
//  2. 16 writes -> full=1. 17th write with data 8'hAA -> ignored.
//     16 reads return the original order; empty=1 after the last.
//  3. Hold 15 entries; write+read in the same cycle -> count stays 15.
//     Continue 40 cycles -> ptr wraps; data order is preserved.
//  4. At full, write_enb+read_enb -> only the read is taken; full drops to 0.
//     At empty, both -> the write is taken and data_out is unchanged.
//  5. Mid-packet (len_cnt=2), soft_reset -> next cycle empty=1, pkt_busy=0, data_out=0.
//     A write in the same cycle is not stored.
//  6. Header 8'h08 (len 2) read; after one payload read, read a new header 8'h04.
//     len_cnt reloads to 2 and pkt_busy stays 1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, header length field and FIFO sizing.
package router_pkg;
   localparam int WIDTH      = 8;
   localparam int LEN_MSB    = 7;
   localparam int LEN_LSB    = 2;
   localparam int LEN_CNT_W  = 7;
   localparam int FIFO_DEPTH = 16;
endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port RAM for one router output FIFO: synchronous write, synchronous read.
// The read register has a clear so the FIFO can zero its data_out on reset or flush.
module router_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int EW    = 9
) (
   input  logic                     clock,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [EW-1:0]            wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   input  logic                     rd_clr,
   output logic [EW-1:0]            rd_data
);
   logic [EW-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (rd_clr)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router. Stores {lfd_tag, byte} entries and tracks
// the remaining length of the packet being read out so ports can be sequenced.
module router_fifo #(
   parameter int DEPTH = router_pkg::FIFO_DEPTH,
   parameter int WIDTH = router_pkg::WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic             full,
   output logic             empty,
   output logic             pkt_busy,
   output logic [WIDTH-1:0] data_out
);
   import router_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]           wr_ptr, rd_ptr;
   logic                  do_wr, do_rd, clr, rd_done;
   logic [WIDTH:0]        rd_q;
   logic [LEN_CNT_W-1:0]  len_reg, len_now;

   // Handshake: write_enb/read_enb are requests; a transfer happens on the edge where the
   // request is high and the FIFO is not full (write) / not empty (read), judged on the
   // pre-edge flags. A request that is not accepted has no effect at all.
   assign clr   = reset || soft_reset;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_wr = write_enb && !full;
   assign do_rd = read_enb && !empty;

   router_fifo_mem #(.DEPTH(DEPTH), .EW(WIDTH + 1)) u_mem (
      .clock   (clock),
      .wr_en   (do_wr && !clr),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data ({lfd_state, data_in}),
      .rd_en   (do_rd),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_clr  (clr),
      .rd_data (rd_q)
   );

   assign data_out = rd_q[WIDTH-1:0];

   always_ff @(posedge clock) begin
      if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_done <= 1'b0;
         len_reg <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW + 1)'(1);
         rd_done <= do_rd;
         len_reg <= len_now;
      end
   end

   // The read entry only exists in rd_q after the edge, so the count for that read is
   // folded in combinationally here and committed to len_reg on the following edge.
   always_comb begin
      len_now = len_reg;
      if (rd_done) begin
         if (rd_q[WIDTH])
            len_now = LEN_CNT_W'(rd_q[LEN_MSB:LEN_LSB]) + LEN_CNT_W'(1);
         else if (len_reg != '0)
            len_now = len_reg - LEN_CNT_W'(1);
      end
   end

   assign pkt_busy = (len_now != '0);
endmodule

// File: tb/tb_router_fifo.sv
// Randomized scoreboard bench for router_fifo against a queue-based reference model.
module tb_router_fifo;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0, soft_reset = 1'b0, write_enb = 1'b0, read_enb = 1'b0, lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic       full, empty, pkt_busy;
  logic [7:0] data_out;

  router_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .write_enb(write_enb),
    .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
    .full(full), .empty(empty), .pkt_busy(pkt_busy), .data_out(data_out)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] m_q[$];
  int         m_len = 0;
  logic [7:0] exp_q[$];
  logic       rd_issue = 1'b0, clr_issue = 1'b0, mon_en = 1'b0;
  logic [7:0] last_exp = '0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops an expected byte after each accepted read, otherwise data_out must hold
  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      if (clr_issue) last_exp = 8'h00;
      else if (rd_issue) begin
        if (exp_q.size() == 0) check("exp_q_underflow", 1, 0);
        else last_exp = exp_q.pop_front();
      end
      check("data_out", data_out, last_exp);
    end
  end

  task automatic check_flags(input string tag);
    check({tag, ":full"}, full, (m_q.size() == DEPTH));
    check({tag, ":empty"}, empty, (m_q.size() == 0));
    check({tag, ":pkt_busy"}, pkt_busy, (m_len != 0));
  endtask

  // one clock of stimulus; called at a negedge, returns at the next negedge
  task automatic step(input logic we, input logic re, input logic lfd, input logic srst,
                      input logic [7:0] din);
    logic       wr_ok, rd_ok;
    logic [8:0] ent;
    write_enb = we; read_enb = re; lfd_state = lfd; soft_reset = srst; data_in = din;
    wr_ok = we && (m_q.size() < DEPTH);
    rd_ok = re && (m_q.size() != 0);
    clr_issue = srst;
    rd_issue  = rd_ok && !srst;
    if (srst) begin
      m_q.delete();
      m_len = 0;
    end else begin
      if (rd_ok) begin
        ent = m_q.pop_front();
        exp_q.push_back(ent[7:0]);
        if (ent[8]) m_len = int'(ent[7:2]) + 1;
        else if (m_len != 0) m_len = m_len - 1;
      end
      if (wr_ok) m_q.push_back({lfd, din});
    end
    @(negedge clock);
    write_enb = 1'b0; read_enb = 1'b0; soft_reset = 1'b0;
    rd_issue = 1'b0; clr_issue = 1'b0;
    check_flags("step");
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    step(1'b1, 1'b0, lfd, 1'b0, d);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1; clr_issue = 1'b1; mon_en = 1'b1;
    m_q.delete(); m_len = 0; exp_q.delete();
    @(negedge clock);
    reset = 1'b0; clr_issue = 1'b0;
    check_flags("reset");
  endtask

  initial begin
    @(negedge clock);
    do_reset();

    // header 0D (len 3) + 3 payload + parity, then read out
    wr(8'h0D, 1'b1);
    for (int i = 0; i < 4; i++) wr(8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 5; i++) rd();

    // fill to full, extra write ignored, drain in order
    for (int i = 0; i < DEPTH; i++) wr(8'($urandom_range(0, 255)), 1'b0);
    wr(8'hAA, 1'b0);
    for (int i = 0; i < DEPTH; i++) rd();

    // hold 15 entries, streaming write+read across the pointer wrap
    for (int i = 0; i < 15; i++) wr(8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 15; i++) rd();

    // simultaneous read+write at full and at empty
    for (int i = 0; i < DEPTH; i++) wr(8'($urandom_range(0, 255)), 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    for (int i = 0; i < DEPTH - 1; i++) rd();
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
    rd();

    // soft reset mid-packet with a concurrent write
    wr(8'h0D, 1'b1);
    for (int i = 0; i < 4; i++) wr(8'($urandom_range(0, 255)), 1'b0);
    rd(); rd(); rd();
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h77);
    rd();

    // truncated packet: a new header reloads the length
    wr(8'h08, 1'b1); wr(8'h11, 1'b0); wr(8'h04, 1'b1); wr(8'h22, 1'b0); wr(8'h33, 1'b0);
    for (int i = 0; i < 5; i++) rd();

    // random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 60) == 0), 8'($urandom_range(0, 255)));
    while (m_q.size() != 0) rd();

    @(negedge clock);
    check("exp_q_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
